tl_input_conditioner: RTL and testbench

Input conditioning stage placed directly upstream of the two-mode traffic-light controller. Synchronises and debounces the raw mode switch and pedestrian button, drives a clean mode level and a clean button level, and holds a pedestrian request until the controller acknowledges it. All controller-facing inputs come only from this block.

---
 rtl/tl_input_pkg.sv | 16 +
 rtl/tl_debounce_ch.sv | 89 ++++++++
 rtl/tl_input_conditioner.sv | 76 +++++++
 tb/tb_tl_input_conditioner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_input_pkg.sv
// Shared types and constants for the traffic-light input conditioner.
// Holds the debounce state encoding, the default debounce length and the synchroniser depth.
package tl_input_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    // 20 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int SYNC_DEPTH          = 2;

endpackage

// File: rtl/tl_debounce_ch.sv
// One input channel: 2-FF synchroniser, then debounce FSM and counter driving a registered clean level.
// Latency: raw to clean level is SYNC_DEPTH + DEBOUNCE_CYCLES + 1 cycles; no backpressure.
module tl_debounce_ch
    import tl_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_clean
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  w_sync;
    db_state_t             r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_clean;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_raw};
        end
    end

    assign w_sync = r_sync[SYNC_DEPTH-1];

    // Clean level is registered alongside the state it belongs to, so it
    // changes on the same edge the FSM enters STABLE_HI / STABLE_LO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else begin
            case (r_state)
                STABLE_LO: begin
                    if (w_sync) begin
                        r_state <= WAIT_HI;
                        r_cnt   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!w_sync) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        r_clean <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!w_sync) begin
                        r_state <= WAIT_LO;
                        r_cnt   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (w_sync) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        r_clean <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                    r_clean <= 1'b0;
                end
            endcase
        end
    end

    assign o_clean = r_clean;

endmodule

// File: rtl/tl_input_conditioner.sv
// Conditions mode switch and pedestrian button for the traffic-light controller; clean levels plus edge outputs.
// Latency: raw to clean level DEBOUNCE_CYCLES+3, clean to ped_req_o/mode_change_o 1 cycle; no backpressure. Option: PED_REQ_LATCH_EN.
module tl_input_conditioner
    import tl_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst,
    input  logic swap_mode_raw_i,
    input  logic button_raw_i,
    input  logic ped_ack_i,
    output logic swap_mode_o,
    output logic mode_change_o,
    output logic button_o,
    output logic ped_req_o
);

    logic w_mode_clean;
    logic w_btn_clean;
    logic w_btn_rise;
    logic r_mode_prev;
    logic r_btn_prev;
    logic r_mode_change;
    logic r_ped_req;

    tl_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_mode_ch (
        .i_clk   (clk_i),
        .i_rst   (rst),
        .i_raw   (swap_mode_raw_i),
        .o_clean (w_mode_clean)
    );

    tl_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_ch (
        .i_clk   (clk_i),
        .i_rst   (rst),
        .i_raw   (button_raw_i),
        .o_clean (w_btn_clean)
    );

    assign w_btn_rise = w_btn_clean & ~r_btn_prev;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_mode_prev   <= 1'b0;
            r_btn_prev    <= 1'b0;
            r_mode_change <= 1'b0;
            r_ped_req     <= 1'b0;
        end else begin
            r_mode_prev   <= w_mode_clean;
            r_btn_prev    <= w_btn_clean;
            r_mode_change <= w_mode_clean ^ r_mode_prev;
`ifdef PED_REQ_LATCH_EN
            // A new press in the ack cycle keeps the request so it is not lost.
            r_ped_req     <= w_btn_rise | (r_ped_req & ~ped_ack_i);
`else
            r_ped_req     <= w_btn_rise;
`endif
        end
    end

`ifndef PED_REQ_LATCH_EN
    logic w_ack_unused;
    assign w_ack_unused = ped_ack_i;
`endif

    assign swap_mode_o   = w_mode_clean;
    assign button_o      = w_btn_clean;
    assign mode_change_o = r_mode_change;
    assign ped_req_o     = r_ped_req;

endmodule

// File: tb/tb_tl_input_conditioner.sv
// Bench for tl_input_conditioner with DEBOUNCE_CYCLES = 4; reference model feeds an expected-output queue.
module tb_tl_input_conditioner;

    localparam int D = 4;
`ifdef PED_REQ_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic swap_raw;
    logic btn_raw;
    logic ack;
    logic swap_mode_o;
    logic mode_change_o;
    logic button_o;
    logic ped_req_o;

    tl_input_conditioner #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk_i           (clk),
        .rst             (rst),
        .swap_mode_raw_i (swap_raw),
        .button_raw_i    (btn_raw),
        .ped_ack_i       (ack),
        .swap_mode_o     (swap_mode_o),
        .mode_change_o   (mode_change_o),
        .button_o        (button_o),
        .ped_req_o       (ped_req_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    typedef struct packed {
        logic swap;
        logic mc;
        logic btn;
        logic ped;
    } obs_t;

    obs_t exp_q[$];

    // Reference model: a channel's clean level flips once the synchronised
    // input has disagreed with it for D+1 consecutive samples.
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_clean [2];
    int   m_n [2];
    logic m_mprev, m_bprev, m_mc, m_ped;
    int   cyc = 0;

    task automatic model_step();
        logic rise;
        logic raw;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_clean[c] = 1'b0; m_n[c] = 0;
            end
            m_mprev = 1'b0; m_bprev = 1'b0; m_mc = 1'b0; m_ped = 1'b0;
        end else begin
            m_mc    = m_clean[0] ^ m_mprev;
            m_mprev = m_clean[0];
            rise    = m_clean[1] & ~m_bprev;
            m_bprev = m_clean[1];
            if (LATCH) m_ped = rise | (m_ped & ~ack);
            else       m_ped = rise;
            for (int c = 0; c < 2; c++) begin
                raw = (c == 0) ? swap_raw : btn_raw;
                if (m_s2[c] != m_clean[c]) begin
                    m_n[c]++;
                    if (m_n[c] == D + 1) begin
                        m_clean[c] = ~m_clean[c];
                        m_n[c]     = 0;
                    end
                end else begin
                    m_n[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw;
            end
        end
        exp_q.push_back('{swap: m_clean[0], mc: m_mc, btn: m_clean[1], ped: m_ped});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    int   mc_hi   = 0;
    int   mc_rise = 0;
    logic mc_last = 1'b0;

    initial begin
        obs_t o;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                o = exp_q.pop_front();
                chk("swap_mode_o",   swap_mode_o,   o.swap);
                chk("mode_change_o", mode_change_o, o.mc);
                chk("button_o",      button_o,      o.btn);
                chk("ped_req_o",     ped_req_o,     o.ped);
            end
            if (mode_change_o === 1'b1) mc_hi++;
            if (mode_change_o === 1'b1 && mc_last !== 1'b1) mc_rise++;
            mc_last = mode_change_o;
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles from now until the selected clean output reaches val; -1 on timeout.
    task automatic wait_out(input int which, input logic val, output int lat);
        int k;
        k   = cyc;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (((which == 0) ? swap_mode_o : button_o) === val) begin
                lat = cyc - k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int mh0, mr0;
        rst = 1'b1; swap_raw = 1'b0; btn_raw = 1'b0; ack = 1'b0;
        cyc_n(3);
        chk("reset_outs", {swap_mode_o, mode_change_o, button_o, ped_req_o}, 4'b0000);
        rst = 1'b0;
        cyc_n(10);
        chk("idle_outs", {swap_mode_o, mode_change_o, button_o, ped_req_o}, 4'b0000);

        // clean press
        btn_raw = 1'b1;
        wait_out(1, 1'b1, lat);
        chk("press_lat", lat, 7);
        @(negedge clk);
        chk("ped_set", ped_req_o, 1'b1);
        cyc_n(5);
        chk("ped_hold", ped_req_o, LATCH);
        btn_raw = 1'b0;
        wait_out(1, 1'b0, lat);
        chk("release_lat", lat, 7);
        cyc_n(3);

        // ack coinciding with a new rising edge of button_o
        btn_raw = 1'b1;
        wait_out(1, 1'b1, lat);
        chk("press2_lat", lat, 7);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ped_ack_race", ped_req_o, 1'b1);
        cyc_n(3);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ped_ack_clr", ped_req_o, 1'b0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ped_ack_idle", ped_req_o, 1'b0);
        btn_raw = 1'b0;
        cyc_n(12);

        // bounce: 1, 2 and 3 cycle pulses
        for (int w = 1; w <= 3; w++) begin
            btn_raw = 1'b1;
            cyc_n(w);
            btn_raw = 1'b0;
            cyc_n(4);
        end
        cyc_n(10);
        chk("bounce_btn", button_o, 1'b0);
        chk("bounce_ped", ped_req_o, 1'b0);

        // mode switch 0 -> 1 -> 0, each level held 20 cycles
        mh0 = mc_hi; mr0 = mc_rise;
        swap_raw = 1'b1;
        wait_out(0, 1'b1, lat);
        chk("mode_up_lat", lat, 7);
        cyc_n(20 - ((lat > 0) ? lat : 0));
        swap_raw = 1'b0;
        wait_out(0, 1'b0, lat);
        chk("mode_dn_lat", lat, 7);
        cyc_n(13);
        chk("mc_pulses", mc_rise - mr0, 2);
        chk("mc_width",  mc_hi - mh0, 2);

        // reset mid-debounce with a request pending
        btn_raw = 1'b1;
        wait_out(1, 1'b1, lat);
        chk("press3_lat", lat, 7);
        cyc_n(2);
        chk("ped_pending", ped_req_o, LATCH);
        btn_raw = 1'b0;
        wait_out(1, 1'b0, lat);
        chk("release3_lat", lat, 7);
        btn_raw = 1'b1;
        cyc_n(5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", {swap_mode_o, mode_change_o, button_o, ped_req_o}, 4'b0000);
        rst = 1'b0;
        wait_out(1, 1'b1, lat);
        chk("rst_relat", lat, 7);
        @(negedge clk);
        chk("rst_ped", ped_req_o, 1'b1);
        cyc_n(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
